// File: rtl/timer_ctrl_pkg.sv
// Shared state encoding and sizing constants for the timer counter controller.
package timer_ctrl_pkg;

  localparam int PSC_W   = 8;
  localparam int MAX_DIV = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } tmr_state_e;

endpackage

// File: rtl/halt_level_qual.sv
// Debug halt level qualifier: asserts only when the condition is seen high
// on two consecutive clock samples, so single-cycle glitches are ignored.
module halt_level_qual (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cond,
  output logic o_qual
);

  logic halt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= i_cond;
    end
  end

  assign o_qual = halt_q & i_cond;

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Timer main-counter sequencer: turns enable/divider controls into a count strobe
// and runs the debug halt handshake (IDLE/RUN/HALT).
module timer_cnt_ctrl #(
  parameter int DIV_W   = 4,
  parameter int PSC_W   = 8,
  parameter int MAX_DIV = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_timer_en,
  input  logic             i_div_en,
  input  logic [DIV_W-1:0] i_div_val,
  input  logic             i_cnt_clr,
  input  logic             i_dbg_mode,
  input  logic             i_halt_req,
  output logic             o_cnt_en,
  output logic             o_halt_ack,
  output logic [1:0]       o_state
);

  import timer_ctrl_pkg::*;

  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  tmr_state_e       state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [DIV_W:0]   cfg_q, cfg_d;
  logic [DIV_W-1:0] div_clamped;
  logic [PSC_W-1:0] pow2;
  logic [PSC_W-1:0] limit;
  logic             halt_cond;
  logic             halt_qual;
  logic             cfg_change;
  logic             at_limit;

  assign halt_cond = i_dbg_mode & i_halt_req;

  halt_level_qual u_halt_qual (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_cond (halt_cond),
    .o_qual (halt_qual)
  );

  // Shadow of the divider config; any difference restarts the prescaler.
  assign cfg_d      = {i_div_en, i_div_val};
  assign cfg_change = (cfg_d != cfg_q);

  always_comb begin
    div_clamped = i_div_val;
    if (int'(i_div_val) > MAX_DIV) begin
      div_clamped = DIV_W'(MAX_DIV);
    end
    pow2  = PSC_ONE << div_clamped;
    limit = i_div_en ? (pow2 - PSC_ONE) : '0;
  end

  assign at_limit = (psc_q == limit);

  always_comb begin
    psc_d = psc_q;
    if ((state_q != RUN) && (state_q != HALT)) begin
      psc_d = '0;
    end else if (i_cnt_clr || cfg_change) begin
      psc_d = '0;
    end else if (state_q == RUN) begin
      psc_d = at_limit ? '0 : (psc_q + PSC_ONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (halt_qual)       state_d = HALT;
        else if (i_timer_en) state_d = RUN;
      end
      RUN: begin
        if (halt_qual)        state_d = HALT;
        else if (!i_timer_en) state_d = IDLE;
      end
      HALT: begin
        if (!halt_cond) state_d = i_timer_en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      psc_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      cfg_q   <= cfg_d;
    end
  end

  assign o_cnt_en   = (state_q == RUN) & at_limit & ~i_cnt_clr & ~cfg_change;
  assign o_halt_ack = (state_q == HALT);
  assign o_state    = state_q;

endmodule
